// File: rtl/goomba_sprite_renderer.sv
// -----------------------------------------------------------------------------
// goomba_sprite_renderer
//
// Per-pixel front end for one Goomba enemy. Maps the current VGA pixel to a
// 21x21 sprite ROM address (optionally mirrored), runs the two-frame walk
// animation and the stomp/squish/despawn sequence, and registers the ROM
// colour plus a pixel-valid flag for the colour mux. Fixed 2-cycle latency:
// pixel sampled at edge t -> read_address after t+1 -> pixel_rgb/valid after t+2.
//
// Ports
//   Clk           system clock, rising edge
//   Reset_n       asynchronous active-low reset
//   frame_tick    one-cycle pulse per video frame
//   DrawX/DrawY   current pixel column/row
//   goomba_x/y    sprite top-left corner
//   flip          1 = mirror sprite horizontally
//   stomp         one-cycle pulse, Mario landed on this Goomba
//   read_address  registered sprite ROM address (0 outside the sprite)
//   walk_frame    registered ROM select, 0 = walk_1, 1 = walk_2
//   rom_color     combinational ROM colour for read_address/walk_frame
//   pixel_rgb     registered colour (loaded every cycle)
//   pixel_valid   registered, 1 = Goomba owns this pixel
//   alive         registered, 0 once despawned
//
// State table
//   state       | meaning
//   ST_ALIVE    | walking, animation running, full sprite drawn
//   ST_SQUISHED | stomped, animation frozen, top rows hidden, squish timer runs
//   ST_GONE     | despawned, nothing drawn, terminal until reset
// -----------------------------------------------------------------------------
module goomba_sprite_renderer #(
    parameter int          SPRITE_W      = 21,
    parameter int          SPRITE_H      = 21,
    parameter int          ANIM_FRAMES   = 8,
    parameter int          SQUISH_FRAMES = 30,
    parameter logic [23:0] TRANSPARENT   = 24'h800080
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  goomba_x,
    input  logic [9:0]  goomba_y,
    input  logic        flip,
    input  logic        stomp,
    output logic [8:0]  read_address,
    output logic        walk_frame,
    input  logic [23:0] rom_color,
    output logic [23:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        alive
);

    localparam int AW = $clog2(ANIM_FRAMES);
    localparam int SW = $clog2(SQUISH_FRAMES);

    typedef enum logic [1:0] {
        ST_ALIVE    = 2'd0,
        ST_SQUISHED = 2'd1,
        ST_GONE     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   anim_q, anim_d;
    logic [SW-1:0]   squish_q, squish_d;
    logic            walk_q, walk_d;
    logic            alive_q;

    logic [8:0]      read_address_q;
    logic            in_win_q;
    logic [4:0]      row_q;
    logic [23:0]     pixel_rgb_q;
    logic            pixel_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: window test and address generation.
    // The 11-bit difference wraps to >= 1025 when DrawX < goomba_x, so a
    // single unsigned compare against the sprite size covers both bounds
    // without any 10-bit wrap-around aliasing.
    // ------------------------------------------------------------------
    logic [10:0] col_w, row_w;
    logic        in_win_w;
    logic [4:0]  col_eff_w;
    logic [8:0]  addr_w;

    always_comb begin
        col_w     = {1'b0, DrawX} - {1'b0, goomba_x};
        row_w     = {1'b0, DrawY} - {1'b0, goomba_y};
        in_win_w  = (col_w < 11'(SPRITE_W)) && (row_w < 11'(SPRITE_H));
        col_eff_w = flip ? (5'(SPRITE_W - 1) - col_w[4:0]) : col_w[4:0];
        addr_w    = '0;
        if (in_win_w) begin
            addr_w = 9'(row_w[4:0]) * 9'(SPRITE_W) + 9'(col_eff_w);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour qualification. State is the post-transition value,
    // so a stomp affects pixels whose stage-2 edge follows it.
    // ------------------------------------------------------------------
    logic show_w;
    logic pixel_valid_d;

    always_comb begin
        show_w = 1'b0;
        case (state_q)
            ST_ALIVE:    show_w = 1'b1;
            ST_SQUISHED: show_w = (row_q >= 5'(SPRITE_H / 2));
            default:     show_w = 1'b0;
        endcase
        pixel_valid_d = in_win_q && (rom_color != TRANSPARENT) && show_w;
    end

    // ------------------------------------------------------------------
    // FSM next state, walk animation and squish timer
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        anim_d   = anim_q;
        squish_d = squish_q;
        walk_d   = walk_q;
        case (state_q)
            ST_ALIVE: begin
                if (stomp) begin
                    // stomp beats a coincident frame_tick: no walk toggle
                    state_d  = ST_SQUISHED;
                    anim_d   = '0;
                    squish_d = '0;
                end else if (frame_tick) begin
                    if (anim_q == AW'(ANIM_FRAMES - 1)) begin
                        anim_d = '0;
                        walk_d = ~walk_q;
                    end else begin
                        anim_d = anim_q + 1'b1;
                    end
                end
            end
            ST_SQUISHED: begin
                if (frame_tick) begin
                    if (squish_q == SW'(SQUISH_FRAMES - 1)) begin
                        state_d = ST_GONE;
                    end else begin
                        squish_d = squish_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_GONE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= ST_ALIVE;
            anim_q         <= '0;
            squish_q       <= '0;
            walk_q         <= 1'b0;
            alive_q        <= 1'b1;
            read_address_q <= '0;
            in_win_q       <= 1'b0;
            row_q          <= '0;
            pixel_rgb_q    <= '0;
            pixel_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            anim_q         <= anim_d;
            squish_q       <= squish_d;
            walk_q         <= walk_d;
            alive_q        <= (state_d != ST_GONE);
            read_address_q <= addr_w;
            in_win_q       <= in_win_w;
            row_q          <= row_w[4:0];
            pixel_rgb_q    <= rom_color;
            pixel_valid_q  <= pixel_valid_d;
        end
    end

    assign read_address = read_address_q;
    assign walk_frame   = walk_q;
    assign pixel_rgb    = pixel_rgb_q;
    assign pixel_valid  = pixel_valid_q;
    assign alive        = alive_q;

endmodule

// File: tb/tb_goomba_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_goomba_sprite_renderer
//
// Drives pixels one per cycle, computes the expected address/colour/valid from
// an independent integer model and pushes them into two queues (address due
// one cycle later, pixel due two cycles later). A negedge monitor pops and
// compares. Animation, stomp, despawn and reset are checked directly.
// -----------------------------------------------------------------------------
module tb_goomba_sprite_renderer;

    localparam logic [23:0] TRANSP = 24'h800080;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, goomba_x = '0, goomba_y = '0;
    logic        flip = 1'b0;
    logic        stomp = 1'b0;
    logic [8:0]  read_address;
    logic        walk_frame;
    logic [23:0] rom_color;
    logic [23:0] pixel_rgb;
    logic        pixel_valid;
    logic        alive;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int mstate = 0;   // 0 alive, 1 squished, 2 gone

    typedef struct {
        int          due;
        string       tag;
        logic [8:0]  addr;
        logic        valid;
        logic [23:0] rgb;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];

    goomba_sprite_renderer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .goomba_x     (goomba_x),
        .goomba_y     (goomba_y),
        .flip         (flip),
        .stomp        (stomp),
        .read_address (read_address),
        .walk_frame   (walk_frame),
        .rom_color    (rom_color),
        .pixel_rgb    (pixel_rgb),
        .pixel_valid  (pixel_valid),
        .alive        (alive)
    );

    always #5 Clk = ~Clk;

    // ROM model: every 7th address (mod 7 == 3) is the transparent key
    function automatic logic [23:0] rom_fn(input logic [8:0] a);
        if ((a % 9'd7) == 9'd3) return TRANSP;
        return 24'hE45810 ^ {15'd0, a};
    endfunction

    assign rom_color = rom_fn(read_address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        cyc++;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            check_eq({aq[0].tag, "_addr"}, 32'(read_address), 32'(aq[0].addr));
            void'(aq.pop_front());
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            check_eq({pq[0].tag, "_valid"}, 32'(pixel_valid), 32'(pq[0].valid));
            check_eq({pq[0].tag, "_rgb"}, 32'(pixel_rgb), 32'(pq[0].rgb));
            void'(pq.pop_front());
        end
    end

    task automatic drive_pixel(input int dx, input int dy, input int gx, input int gy,
                               input bit fl, input string tag);
        int c, r, ce, a;
        bit inw, shw;
        exp_t e;
        @(negedge Clk);
        #1;
        DrawX = 10'(dx); DrawY = 10'(dy); goomba_x = 10'(gx); goomba_y = 10'(gy); flip = fl;
        c   = dx - gx;
        r   = dy - gy;
        inw = (dx >= gx) && (dx < gx + 21) && (dy >= gy) && (dy < gy + 21);
        ce  = fl ? 20 - c : c;
        a   = inw ? r * 21 + ce : 0;
        shw = (mstate == 0) || (mstate == 1 && r >= 10);
        e.tag   = tag;
        e.addr  = 9'(a);
        e.rgb   = rom_fn(9'(a));
        e.valid = inw && (e.rgb != TRANSP) && shw;
        e.due   = cyc + 1;
        aq.push_back(e);
        e.due   = cyc + 2;
        pq.push_back(e);
    endtask

    task automatic park_and_drain();
        @(negedge Clk);
        #1;
        DrawX = 10'd600; DrawY = 10'd600; goomba_x = 10'd0; goomba_y = 10'd0; flip = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic pulse(input bit ft, input bit st);
        @(negedge Clk);
        #1;
        frame_tick = ft; stomp = st;
        @(negedge Clk);
        frame_tick = 1'b0; stomp = 1'b0;
    endtask

    task automatic random_burst(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive_pixel(95 + int'($urandom_range(0, 30)), 195 + int'($urandom_range(0, 30)),
                        100, 200, 1'($urandom_range(0, 1)), tag);
        end
        park_and_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge Clk);
        check_eq("rst_addr",  32'(read_address), 32'd0);
        check_eq("rst_walk",  32'(walk_frame),   32'd0);
        check_eq("rst_rgb",   32'(pixel_rgb),    32'd0);
        check_eq("rst_valid", 32'(pixel_valid),  32'd0);
        check_eq("rst_alive", 32'(alive),        32'd1);
        #1 Reset_n = 1'b1;

        // ---------------- addressing / window / transparency ----------------
        drive_pixel(105, 203, 100, 200, 0, "addr68");
        drive_pixel(105, 203, 100, 200, 1, "addr78_flip");
        drive_pixel(120, 200, 100, 200, 0, "edge_x120");
        drive_pixel(121, 200, 100, 200, 0, "edge_x121");
        drive_pixel(105, 199, 100, 200, 0, "edge_y199");
        drive_pixel(3,   203, 1015, 200, 0, "wrap_x1015");
        drive_pixel(103, 200, 100, 200, 0, "transp");
        drive_pixel(100, 200, 100, 200, 0, "opaque_e45810");
        drive_pixel(120, 220, 100, 200, 1, "corner_flip");
        park_and_drain();
        random_burst(40, "rnd_alive");

        // ---------------- walk animation ----------------
        for (int k = 1; k <= 16; k++) begin
            pulse(1, 0);
            check_eq($sformatf("walk_tick%0d", k), 32'(walk_frame),
                     (k >= 8 && k < 16) ? 32'd1 : 32'd0);
        end

        // ---------------- stomp on 8th tick ----------------
        for (int k = 1; k <= 7; k++) pulse(1, 0);
        check_eq("walk_pre_stomp", 32'(walk_frame), 32'd0);
        pulse(1, 1);
        mstate = 1;
        check_eq("walk_stomp_hold", 32'(walk_frame), 32'd0);
        check_eq("alive_squished",  32'(alive),      32'd1);

        drive_pixel(105, 205, 100, 200, 0, "sq_row5");
        drive_pixel(105, 209, 100, 200, 0, "sq_row9");
        drive_pixel(105, 210, 100, 200, 0, "sq_row10");
        drive_pixel(105, 215, 100, 200, 0, "sq_row15");
        park_and_drain();
        random_burst(30, "rnd_squished");

        pulse(0, 1);
        check_eq("alive_restomp", 32'(alive), 32'd1);

        for (int k = 1; k <= 29; k++) begin
            pulse(1, 0);
            check_eq($sformatf("squish_tick%0d_walk", k), 32'(walk_frame), 32'd0);
        end
        check_eq("alive_tick29", 32'(alive), 32'd1);
        pulse(1, 0);
        mstate = 2;
        check_eq("alive_tick30", 32'(alive), 32'd0);

        random_burst(20, "rnd_gone");
        pulse(0, 1);
        pulse(1, 1);
        check_eq("gone_stomp_alive", 32'(alive), 32'd0);
        check_eq("gone_stomp_walk",  32'(walk_frame), 32'd0);

        // ---------------- reset mid-squish ----------------
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        mstate = 0;
        for (int k = 1; k <= 8; k++) pulse(1, 0);
        check_eq("walk_after_rst8", 32'(walk_frame), 32'd1);
        pulse(0, 1);
        mstate = 1;
        for (int k = 1; k <= 3; k++) pulse(1, 0);
        @(negedge Clk);
        #1;
        DrawX = 10'd105; DrawY = 10'd215; goomba_x = 10'd100; goomba_y = 10'd200; flip = 1'b0;
        repeat (2) @(negedge Clk);
        check_eq("presq_valid", 32'(pixel_valid), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check_eq("arst_addr",  32'(read_address), 32'd0);
        check_eq("arst_walk",  32'(walk_frame),   32'd0);
        check_eq("arst_rgb",   32'(pixel_rgb),    32'd0);
        check_eq("arst_valid", 32'(pixel_valid),  32'd0);
        check_eq("arst_alive", 32'(alive),        32'd1);
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        mstate = 0;

        drive_pixel(105, 205, 100, 200, 0, "fresh_row5");
        drive_pixel(105, 203, 100, 200, 1, "fresh_flip");
        park_and_drain();
        for (int k = 1; k <= 7; k++) pulse(1, 0);
        check_eq("fresh_walk7", 32'(walk_frame), 32'd0);
        pulse(1, 0);
        check_eq("fresh_walk8", 32'(walk_frame), 32'd1);

        repeat (4) @(negedge Clk);
        check_eq("queues_drained", 32'(aq.size() + pq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/goomba_sprite_renderer.md
# goomba_sprite_renderer

Per-pixel front end for one Goomba enemy, sitting between the VGA pixel counter and the Goomba walk-frame sprite ROMs. Each cycle it maps the current (DrawX, DrawY) to a 21x21 sprite ROM address, with optional horizontal mirroring. It runs the two-frame walk animation and the stomp/squish/despawn state machine. It consumes the ROM's 24-bit palette colour and emits a registered colour plus a pixel-valid flag for the colour mux, with transparent key colour removed.

## Interface
- SPRITE_W, 21, sprite width in pixels
- SPRITE_H, 21, sprite height in pixels
- ANIM_FRAMES, 8, frame_tick count per walk-frame toggle
- SQUISH_FRAMES, 30, frame_tick count spent squished before despawn
- TRANSPARENT, 24'h800080, palette key colour treated as see-through
- Clk  in  1  system clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse once per video frame
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- goomba_x  in  10  sprite top-left column
- goomba_y  in  10  sprite top-left row
- flip  in  1  1 = mirror sprite horizontally
- stomp  in  1  one-cycle pulse: Mario landed on this Goomba
- read_address  out  9  registered sprite ROM address
- walk_frame  out  1  registered ROM select: 0 = walk_1, 1 = walk_2
- rom_color  in  24  combinational ROM output for read_address / walk_frame
- pixel_rgb  out  24  registered colour to the colour mux
- pixel_valid  out  1  registered; 1 = Goomba owns this pixel
- alive  out  1  registered; 0 once despawned

## Operation
- Window test: col = DrawX - goomba_x, row = DrawY - goomba_y, computed in 11 bits. in_win = DrawX >= goomba_x && DrawX < goomba_x + SPRITE_W && DrawY >= goomba_y && DrawY < goomba_y + SPRITE_H, with 11-bit sums (no 10-bit wrap; a sprite at goomba_x = 1015 never matches DrawX = 3).
- col_eff = flip ? SPRITE_W-1-col : col. address = row*SPRITE_W + col_eff, range 0..440. If not in_win, address = 0.
- Stage 1 registers: read_address, in_win_d, row_d.
- Stage 2 registers pixel_rgb <= rom_color and pixel_valid <= in_win_d && rom_color != TRANSPARENT && show, where show depends on state:
  - ALIVE: 1
  - SQUISHED: row_d >= SPRITE_H/2 (top 10 rows suppressed)
  - GONE: 0
- When pixel_valid would be 0, pixel_rgb is still loaded with rom_color; consumers ignore it.
- FSM states ALIVE, SQUISHED, GONE:
  - ALIVE -> SQUISHED on stomp; anim counter cleared to 0.
  - SQUISHED -> GONE when the squish counter reaches SQUISH_FRAMES-1 on a frame_tick.
  - GONE is terminal until reset. alive = (state != GONE).
- Animation, ALIVE only: anim counter increments on frame_tick. At ANIM_FRAMES-1 it wraps to 0 and walk_frame toggles. In SQUISHED and GONE, walk_frame holds.
- Squish counter: cleared on entry to SQUISHED; increments on frame_tick while in SQUISHED.
- Simultaneous events:
  - stomp with frame_tick in ALIVE: stomp wins; no walk toggle this cycle.
  - stomp in SQUISHED or GONE: ignored.

## Timing
- DrawX/DrawY/goomba_x/goomba_y/flip sampled at edge t. read_address is valid after t+1. rom_color must settle within the same cycle (combinational ROM). pixel_rgb/pixel_valid are valid after t+2.
- Fixed latency is 2 cycles; the pixel counter owner compensates upstream.
- State changes take effect for pixels whose stage-2 edge follows the transition edge.
- Reset (asynchronous assert, any time, including mid-squish) forces:
  - read_address 0, walk_frame 0, pixel_rgb 0, pixel_valid 0, alive 1
  - state ALIVE, both counters 0
- Reset deassertion is synchronised by the system; first normal update is on the first edge with Reset_n = 1.

## Test plan
- Reset: assert Reset_n = 0 mid-SQUISHED -> all outputs immediately read_address 0, walk_frame 0, pixel_rgb 0, pixel_valid 0, alive 1. After release, behaviour matches a fresh ALIVE state.
- Addressing: goomba at (100,200), DrawX = 105, DrawY = 203, flip = 0 -> read_address = 68 one cycle later. With flip = 1 -> read_address = 78.
- Window edges: goomba at (100,200), DrawX = 120 -> in window, read_address = 20. DrawX = 121 or DrawY = 199 -> read_address 0, pixel_valid 0 two cycles later. goomba_x = 1015, DrawX = 3 -> pixel_valid 0.
- Transparency, in window:
  - rom_color = 24'h800080 -> pixel_valid 0 at t+2.
  - rom_color = 24'hE45810 -> pixel_valid 1, pixel_rgb = 24'hE45810 at t+2.
- Animation: 8 frame_tick pulses -> walk_frame 0 -> 1 on the 8th tick. 16 ticks -> back to 0. No toggle on any other tick.
- Stomp sequence: stomp coincident with the 8th frame_tick -> walk_frame stays 0 and state is SQUISHED. Then:
  - row 5 opaque pixel -> pixel_valid 0; row 15 opaque pixel -> pixel_valid 1.
  - 30 frame_tick pulses later -> alive 0, pixel_valid 0 everywhere.
  - Further stomp pulses -> no change.
